// File: rtl/hamming72_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming72_decoder: 2-stage SECDED decoder for a 72-bit extended Hamming   |
// | codeword with valid/ready handshakes. Option: HAMMING_DEC_STATS_EN.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module hamming72_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [6:0]       syndrome,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  // Syndrome bit k covers every code position whose index has bit k set.
  localparam logic [71:0] C_SYN_M0 = 72'hAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [71:0] C_SYN_M1 = 72'hCC_CCCC_CCCC_CCCC_CCCC;
  localparam logic [71:0] C_SYN_M2 = 72'hF0_F0F0_F0F0_F0F0_F0F0;
  localparam logic [71:0] C_SYN_M3 = 72'h00_FF00_FF00_FF00_FF00;
  localparam logic [71:0] C_SYN_M4 = 72'h00_FFFF_0000_FFFF_0000;
  localparam logic [71:0] C_SYN_M5 = 72'h00_FFFF_FFFF_0000_0000;
  localparam logic [71:0] C_SYN_M6 = 72'hFF_0000_0000_0000_0000;

  logic        s1_valid_q;
  logic [63:0] s1_data_q;
  logic [6:0]  s1_syn_q;
  logic        s1_par_q;

  logic        out_valid_q;
  logic [63:0] data_q;
  logic        single_q;
  logic        double_q;
  logic [6:0]  syn_q;

  logic [6:0]  syn_d;
  logic        par_d;
  logic [63:0] raw_d;
  logic [71:0] flip_vec_d;
  logic [63:0] flip_data_d;
  logic        single_d;
  logic        double_d;
  logic [63:0] data_d;
  logic        s2_ready_d;
  logic        unused_flip;

  assign s2_ready_d = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_ready_d;

  always_comb begin
    syn_d[0] = ^(code_in & C_SYN_M0);
    syn_d[1] = ^(code_in & C_SYN_M1);
    syn_d[2] = ^(code_in & C_SYN_M2);
    syn_d[3] = ^(code_in & C_SYN_M3);
    syn_d[4] = ^(code_in & C_SYN_M4);
    syn_d[5] = ^(code_in & C_SYN_M5);
    syn_d[6] = ^(code_in & C_SYN_M6);
    par_d    = ^code_in;
    raw_d    = {code_in[71:65], code_in[63:33], code_in[31:17],
                code_in[15:9], code_in[7:5], code_in[3]};
  end

  // A syndrome of 0 with odd parity points at bit 0, which carries no data,
  // so the flip mask naturally leaves the data untouched in that case.
  always_comb begin
    flip_vec_d  = 72'd1 << s1_syn_q;
    flip_data_d = {flip_vec_d[71:65], flip_vec_d[63:33], flip_vec_d[31:17],
                   flip_vec_d[15:9], flip_vec_d[7:5], flip_vec_d[3]};
    single_d    = s1_par_q && (s1_syn_q <= 7'd71);
    double_d    = s1_par_q ? (s1_syn_q > 7'd71) : (s1_syn_q != 7'd0);
    data_d      = s1_data_q ^ (single_d ? flip_data_d : 64'd0);
  end

  assign unused_flip = ^{flip_vec_d[64], flip_vec_d[32], flip_vec_d[16],
                         flip_vec_d[8], flip_vec_d[4], flip_vec_d[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= 64'd0;
      s1_syn_q    <= 7'd0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= 64'd0;
      single_q    <= 1'b0;
      double_q    <= 1'b0;
      syn_q       <= 7'd0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= raw_d;
          s1_syn_q  <= syn_d;
          s1_par_q  <= par_d;
        end
      end
      if (s2_ready_d) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          data_q   <= data_d;
          single_q <= single_d;
          double_q <= double_d;
          syn_q    <= s1_syn_q;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign err_single = single_q;
  assign err_double = double_q;
  assign syndrome   = syn_q;

`ifdef HAMMING_DEC_STATS_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] sec_q;
  logic [CNT_W-1:0] ded_q;
  logic             fire_d;

  assign fire_d = out_valid_q && out_ready;

  // Clear takes priority; an increment in the same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= '0;
      ded_q <= '0;
    end else if (clr_counts) begin
      sec_q <= '0;
      ded_q <= '0;
    end else if (fire_d) begin
      if (single_q && (sec_q != C_CNT_MAX)) sec_q <= sec_q + 1'b1;
      if (double_q && (ded_q != C_CNT_MAX)) ded_q <= ded_q + 1'b1;
    end
  end

  assign sec_count = sec_q;
  assign ded_count = ded_q;
`else
  logic unused_clr;
  assign unused_clr = clr_counts;
  assign sec_count  = '0;
  assign ded_count  = '0;
`endif

endmodule
`default_nettype wire
